// File: rtl/gty_bringup_pkg.sv
// Shared definitions for the GTY quad bring-up sequencer.
//
// Contents:
//   state_e        - sequencer state encoding, also driven onto state_out_o
//   COUNTER_WIDTH  - width of the single dwell/timeout counter shared by all states
//   retry_width()  - width of the retry counter for a given retry budget
package gty_bringup_pkg;

    localparam int COUNTER_WIDTH = 24;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_PGOOD = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_PMA   = 3'd3,
        ST_WAIT_LINK  = 3'd4,
        ST_RUNNING    = 3'd5,
        ST_FAULT      = 3'd6
    } state_e;

    // Bits needed to hold 0..max_retries; never less than one bit.
    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/gty_bringup_ctl_sync.sv
// bringup_sync: parametrised-width two-flop synchroniser into the clk domain.
//
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset, clears both stages to 0
//   d_i    - asynchronous input bus (bits are synchronised independently)
//   q_o    - synchronised bus, two clk cycles behind d_i
module bringup_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages; only sync_q is consumed downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gty_bringup_ctl.sv
// gty_bringup_ctl: bring-up and supervision sequencer for one GTY quad (or a
// subset of its lanes) plus the per-lane PCS link status.
//
// Sequence: RESET (reset-all pulse) -> WAIT_PGOOD -> SETTLE (power-good must
// hold) -> WAIT_PMA (tx/rx PMA reset done) -> WAIT_LINK (required lanes up)
// -> RUNNING. PMA and link waits are bounded; a timeout restarts from RESET
// until the retry budget is spent, after which FAULT is latched.
//
// Optional build macro GTY_BRINGUP_DROP_COUNT_EN: per-lane 16-bit saturating
// counters of link drops seen while RUNNING. Without it drop_count_o is 0.
//
// Ports:
//   clk_i               free-running 125 MHz clock
//   rst_i               synchronous active-high reset
//   manual_reset_i      single-cycle restart request, clears retries and fault
//   lane_required_i     lanes that must be linked before RUNNING
//   pwrgood_i           gtpowergood per lane (asynchronous)
//   tx_pmaresetdone_i   tx PMA reset done per lane (asynchronous)
//   rx_pmaresetdone_i   rx PMA reset done per lane (asynchronous)
//   link_up_i           PCS link status per lane (rx_usrclk domain)
//   gty_reset_all_o     to gtwiz_reset_all_in
//   tx_clock_stable_o   to gtwiz_userclk_tx_active_in
//   rx_clock_stable_o   to gtwiz_userclk_rx_active_in
//   lanes_up_o          synchronised link_up
//   state_out_o         current state encoding
//   retry_count_o       timeout restarts since rst_i / manual_reset_i
//   running_o           state is RUNNING
//   fault_o             sticky retry exhaustion
//   drop_count_o        per-lane link-drop counters, lane i at [16i+15:16i]
module gty_bringup_ctl
    import gty_bringup_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int RST_CYCLES    = 128,
    parameter int SETTLE_CYCLES = 65535,
    parameter int PMA_TIMEOUT   = 1000000,
    parameter int LINK_TIMEOUT  = 12500000,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      manual_reset_i,
    input  logic [NUM_LANES-1:0]      lane_required_i,
    input  logic [NUM_LANES-1:0]      pwrgood_i,
    input  logic [NUM_LANES-1:0]      tx_pmaresetdone_i,
    input  logic [NUM_LANES-1:0]      rx_pmaresetdone_i,
    input  logic [NUM_LANES-1:0]      link_up_i,
    output logic                      gty_reset_all_o,
    output logic                      tx_clock_stable_o,
    output logic                      rx_clock_stable_o,
    output logic [NUM_LANES-1:0]      lanes_up_o,
    output logic [2:0]                state_out_o,
    output logic [2:0]                retry_count_o,
    output logic                      running_o,
    output logic                      fault_o,
    output logic [16*NUM_LANES-1:0]   drop_count_o
);

    localparam int RW = retry_width(MAX_RETRIES);

    // Counter compare points: each state leaves on the cycle the counter
    // shows LIMIT-1, so the state has lasted exactly LIMIT cycles.
    localparam logic [COUNTER_WIDTH-1:0] RST_LIM    = COUNTER_WIDTH'(RST_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] SETTLE_LIM = COUNTER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] PMA_LIM    = COUNTER_WIDTH'(PMA_TIMEOUT - 1);
    localparam logic [COUNTER_WIDTH-1:0] LINK_LIM   = COUNTER_WIDTH'(LINK_TIMEOUT - 1);
    localparam logic [RW-1:0]            RETRY_MAX  = RW'(MAX_RETRIES);

    // Synchronised copies of the asynchronous inputs.
    logic [NUM_LANES-1:0] pwrgood_s;
    logic [NUM_LANES-1:0] txdone_s;
    logic [NUM_LANES-1:0] rxdone_s;
    logic [NUM_LANES-1:0] lanes_s;

    bringup_sync #(.WIDTH(NUM_LANES)) u_sync_pwrgood (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (pwrgood_i),         .q_o (pwrgood_s)
    );
    bringup_sync #(.WIDTH(NUM_LANES)) u_sync_txdone (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (tx_pmaresetdone_i), .q_o (txdone_s)
    );
    bringup_sync #(.WIDTH(NUM_LANES)) u_sync_rxdone (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (rx_pmaresetdone_i), .q_o (rxdone_s)
    );
    bringup_sync #(.WIDTH(NUM_LANES)) u_sync_link (
        .clk_i (clk_i), .rst_i (rst_i), .d_i (link_up_i),         .q_o (lanes_s)
    );

    state_e                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]              retry_q, retry_d;
    logic                       fault_q, fault_d;
    logic                       reset_all_q, reset_all_d;
    logic                       clk_stable_q, clk_stable_d;
    logic                       running_q, running_d;

    logic                       all_pgood_s;
    logic                       all_pma_s;
    logic                       link_ok_s;

    assign all_pgood_s = &pwrgood_s;
    assign all_pma_s   = (&txdone_s) & (&rxdone_s);
    assign link_ok_s   = ((lanes_s & lane_required_i) == lane_required_i);

    // Next-state, retry and fault logic. Priority: manual restart, then
    // power-good loss, then normal progress, then timeout.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fault_d = fault_q;
        if (manual_reset_i) begin
            state_d = ST_RESET;
            retry_d = '0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q >= RST_LIM) begin
                        state_d = ST_WAIT_PGOOD;
                    end else begin
                        state_d = ST_RESET;
                    end
                end
                ST_WAIT_PGOOD: begin
                    if (all_pgood_s) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_WAIT_PGOOD;
                    end
                end
                ST_SETTLE: begin
                    if (!all_pgood_s) begin
                        state_d = ST_WAIT_PGOOD;
                    end else if (cnt_q >= SETTLE_LIM) begin
                        state_d = ST_WAIT_PMA;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_WAIT_PMA: begin
                    if (!all_pgood_s) begin
                        state_d = ST_WAIT_PGOOD;
                    end else if (all_pma_s) begin
                        state_d = ST_WAIT_LINK;
                    end else if (cnt_q >= PMA_LIM) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RW'(1);
                            state_d = ST_RESET;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end else begin
                        state_d = ST_WAIT_PMA;
                    end
                end
                ST_WAIT_LINK: begin
                    if (!all_pgood_s) begin
                        state_d = ST_WAIT_PGOOD;
                    end else if (link_ok_s) begin
                        state_d = ST_RUNNING;
                    end else if (cnt_q >= LINK_LIM) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RW'(1);
                            state_d = ST_RESET;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end else begin
                        state_d = ST_WAIT_LINK;
                    end
                end
                ST_RUNNING: begin
                    if (!all_pgood_s) begin
                        state_d = ST_WAIT_PGOOD;
                    end else if (!link_ok_s) begin
                        state_d = ST_WAIT_LINK;
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // Outputs are a function of the state being entered so they register
    // in the same edge as the transition. Clock-stable is only held in the
    // states reachable through a completed SETTLE.
    always_comb begin
        reset_all_d  = 1'b0;
        clk_stable_d = 1'b0;
        running_d    = 1'b0;
        case (state_d)
            ST_RESET:     reset_all_d  = 1'b1;
            ST_WAIT_PMA:  clk_stable_d = 1'b1;
            ST_WAIT_LINK: clk_stable_d = 1'b1;
            ST_RUNNING: begin
                clk_stable_d = 1'b1;
                running_d    = 1'b1;
            end
            default: begin
                reset_all_d  = 1'b0;
                clk_stable_d = 1'b0;
                running_d    = 1'b0;
            end
        endcase
    end

    // Shared dwell counter: restarts on any state change or restart request
    // (a restart while already in RESET must still give a full pulse) and
    // parks at all-ones rather than wrapping.
    always_comb begin
        if (manual_reset_i || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != {COUNTER_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            retry_q      <= '0;
            fault_q      <= 1'b0;
            reset_all_q  <= 1'b1;
            clk_stable_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            fault_q      <= fault_d;
            reset_all_q  <= reset_all_d;
            clk_stable_q <= clk_stable_d;
            running_q    <= running_d;
        end
    end

    assign gty_reset_all_o   = reset_all_q;
    assign tx_clock_stable_o = clk_stable_q;
    assign rx_clock_stable_o = clk_stable_q;
    assign lanes_up_o        = lanes_s;
    assign state_out_o       = state_q;
    assign retry_count_o     = 3'(retry_q);
    assign running_o         = running_q;
    assign fault_o           = fault_q;

`ifdef GTY_BRINGUP_DROP_COUNT_EN
    logic [NUM_LANES-1:0]       lanes_prev_q;
    logic [NUM_LANES-1:0][15:0] drop_cnt_q, drop_cnt_d;

    // A drop is a 1->0 step of the synchronised link while RUNNING; the
    // counter sticks at 16'hFFFF.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lanes_prev_q[i] && !lanes_s[i] && (state_q == ST_RUNNING) &&
                (drop_cnt_q[i] != 16'hFFFF)) begin
                drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
            end else begin
                drop_cnt_d[i] = drop_cnt_q[i];
            end
        end
    end

    // Drop counters and previous-link history.
    always_ff @(posedge clk_i) begin
        if (rst_i || manual_reset_i) begin
            lanes_prev_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            lanes_prev_q <= lanes_s;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_gty_bringup_ctl.sv
// Self-checking bench for gty_bringup_ctl with shortened timing parameters.
// Expected state transitions are queued as stimulus is applied and compared
// in order as the DUT changes state; other checks are direct.
module tb_gty_bringup_ctl;

    localparam int NL     = 4;
    localparam int RST_C  = 16;
    localparam int SET_C  = 40;
    localparam int PMA_T  = 100;
    localparam int LINK_T = 200;
    localparam int MAXR   = 2;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WPG    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WPMA   = 3'd3;
    localparam logic [2:0] S_WLINK  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

`ifdef GTY_BRINGUP_DROP_COUNT_EN
    localparam int EXP_D0 = 5;
    localparam int EXP_D1 = 1;
    localparam int EXP_D3 = 1;
`else
    localparam int EXP_D0 = 0;
    localparam int EXP_D1 = 0;
    localparam int EXP_D3 = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            manual_reset;
    logic [NL-1:0]   lane_required, pwrgood, txd, rxd, link;
    logic            gty_reset_all, tx_cs, rx_cs, running, fault;
    logic [NL-1:0]   lanes_up;
    logic [2:0]      state_out, retry_count;
    logic [16*NL-1:0] drop_count;

    gty_bringup_ctl #(
        .NUM_LANES(NL), .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C),
        .PMA_TIMEOUT(PMA_T), .LINK_TIMEOUT(LINK_T), .MAX_RETRIES(MAXR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .manual_reset_i(manual_reset),
        .lane_required_i(lane_required), .pwrgood_i(pwrgood),
        .tx_pmaresetdone_i(txd), .rx_pmaresetdone_i(rxd), .link_up_i(link),
        .gty_reset_all_o(gty_reset_all), .tx_clock_stable_o(tx_cs),
        .rx_clock_stable_o(rx_cs), .lanes_up_o(lanes_up),
        .state_out_o(state_out), .retry_count_o(retry_count),
        .running_o(running), .fault_o(fault), .drop_count_o(drop_count)
    );

    always #4 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_state;
    logic       prev_ra;
    int         ra_rises = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: land on the falling edge, match any state change against
    // the scoreboard and count reset-all rising edges.
    task automatic step();
        logic [2:0] e;
        @(negedge clk);
        if (state_out !== prev_state) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected", {29'd0, state_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_state", {29'd0, state_out}, {29'd0, e});
            end
            prev_state = state_out;
        end
        if (gty_reset_all && !prev_ra) ra_rises++;
        prev_ra = gty_reset_all;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_out !== s && n < budget) begin
            step();
            n++;
        end
        check_val("wait_state", {29'd0, state_out}, {29'd0, s});
    endtask

    initial begin
        int n;
        int ra0;
        rst = 1'b1; manual_reset = 1'b0;
        lane_required = 4'hF; pwrgood = 4'h0; txd = 4'h0; rxd = 4'h0; link = 4'h0;
        repeat (4) @(negedge clk);
        prev_state = state_out;
        prev_ra    = gty_reset_all;

        // Reset values
        check_val("rst_state", {29'd0, state_out}, 32'd0);
        check_val("rst_reset_all", {31'd0, gty_reset_all}, 32'd1);
        check_val("rst_tx_cs", {31'd0, tx_cs}, 32'd0);
        check_val("rst_rx_cs", {31'd0, rx_cs}, 32'd0);
        check_val("rst_lanes_up", {28'd0, lanes_up}, 32'd0);
        check_val("rst_retry", {29'd0, retry_count}, 32'd0);
        check_val("rst_fault", {31'd0, fault}, 32'd0);
        check_val("rst_running", {31'd0, running}, 32'd0);
        check_val("rst_drop", {31'd0, |drop_count}, 32'd0);

        // Nominal bring-up
        exp_q.push_back(S_WPG);
        rst = 1'b0;
        n = 0;
        while (gty_reset_all && n < 1000) begin
            step();
            n++;
        end
        check_val("reset_all_width", n, RST_C);
        repeat (20) step();
        check_val("wpg_state", {29'd0, state_out}, {29'd0, S_WPG});
        check_val("wpg_tx_cs", {31'd0, tx_cs}, 32'd0);

        exp_q.push_back(S_SETTLE); exp_q.push_back(S_WPMA);
        pwrgood = 4'hF;
        step();
        n = 0;
        while (!tx_cs && n < 1000) begin
            step();
            n++;
        end
        check_val("settle_latency", n, SET_C + 2);
        check_val("rx_cs_up", {31'd0, rx_cs}, 32'd1);

        repeat (50) step();
        exp_q.push_back(S_WLINK);
        txd = 4'hF; rxd = 4'hF;
        repeat (60) step();
        check_val("wlink_state", {29'd0, state_out}, {29'd0, S_WLINK});
        exp_q.push_back(S_RUN);
        link = 4'hF;
        wait_state(S_RUN, 20);
        check_val("nom_running", {31'd0, running}, 32'd1);
        check_val("nom_retry", {29'd0, retry_count}, 32'd0);
        check_val("nom_lanes_up", {28'd0, lanes_up}, 32'hF);
        check_val("nom_reset_all", {31'd0, gty_reset_all}, 32'd0);

        // Link drop on a non-required lane, then on a required lane
        lane_required = 4'b0011;
        link = 4'b0111;
        repeat (10) step();
        check_val("lane3_drop_state", {29'd0, state_out}, {29'd0, S_RUN});
        check_val("lane3_drop_lanes", {28'd0, lanes_up}, 32'h7);
        link = 4'hF;
        repeat (5) step();
        exp_q.push_back(S_WLINK);
        link = 4'b1101;
        repeat (6) step();
        check_val("lane1_drop_state", {29'd0, state_out}, {29'd0, S_WLINK});
        check_val("lane1_drop_retry", {29'd0, retry_count}, 32'd0);
        check_val("lane1_drop_running", {31'd0, running}, 32'd0);
        exp_q.push_back(S_RUN);
        link = 4'hF;
        wait_state(S_RUN, 20);

        // Drop counter: five low pulses on non-required lane 0
        lane_required = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            link = 4'b1110;
            repeat (3) step();
            link = 4'hF;
            repeat (3) step();
        end
        repeat (3) step();
        check_val("drop_run_state", {29'd0, state_out}, {29'd0, S_RUN});
        check_val("drop_lane0", {16'd0, drop_count[15:0]}, EXP_D0);
        check_val("drop_lane1", {16'd0, drop_count[31:16]}, EXP_D1);
        check_val("drop_lane3", {16'd0, drop_count[63:48]}, EXP_D3);

        // Power loss in RUNNING
        exp_q.push_back(S_WPG);
        pwrgood = 4'b1110;
        n = 0;
        while (tx_cs && n < 10) begin
            step();
            n++;
        end
        check_val("pwr_loss_latency", n, 3);
        check_val("pwr_loss_state", {29'd0, state_out}, {29'd0, S_WPG});
        check_val("pwr_loss_rx_cs", {31'd0, rx_cs}, 32'd0);

        // Settle glitch: one-cycle low on pwrgood[2] midway through SETTLE
        exp_q.push_back(S_SETTLE);
        pwrgood = 4'hF;
        wait_state(S_SETTLE, 10);
        repeat (20) step();
        exp_q.push_back(S_WPG); exp_q.push_back(S_SETTLE); exp_q.push_back(S_WPMA);
        exp_q.push_back(S_WLINK); exp_q.push_back(S_RUN);
        pwrgood = 4'b1011;
        step();
        pwrgood = 4'hF;
        step();
        n = 0;
        while (!tx_cs && n < 1000) begin
            step();
            n++;
        end
        check_val("glitch_settle_latency", n, SET_C + 2);
        wait_state(S_RUN, 20);

        // Link timeout, retries, fault
        exp_q.push_back(S_WLINK);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(S_RESET); exp_q.push_back(S_WPG); exp_q.push_back(S_SETTLE);
            exp_q.push_back(S_WPMA); exp_q.push_back(S_WLINK);
        end
        exp_q.push_back(S_FAULT);
        ra0 = ra_rises;
        lane_required = 4'hF;
        link = 4'h0;
        wait_state(S_WLINK, 10);
        n = 0;
        while (state_out == S_WLINK && n < 1000) begin
            step();
            n++;
        end
        check_val("link_timeout_len", n, LINK_T);
        check_val("retry_after_first", {29'd0, retry_count}, 32'd1);
        n = 0;
        while (!fault && n < 5000) begin
            step();
            n++;
        end
        check_val("fault_set", {31'd0, fault}, 32'd1);
        check_val("fault_state", {29'd0, state_out}, {29'd0, S_FAULT});
        check_val("fault_retry", {29'd0, retry_count}, MAXR);
        check_val("fault_reset_all", {31'd0, gty_reset_all}, 32'd0);
        check_val("fault_tx_cs", {31'd0, tx_cs}, 32'd0);
        check_val("reset_pulses", ra_rises - ra0, MAXR);
        repeat (30) step();
        check_val("fault_holds", {29'd0, state_out}, {29'd0, S_FAULT});

        // Manual reset out of FAULT
        exp_q.push_back(S_RESET); exp_q.push_back(S_WPG); exp_q.push_back(S_SETTLE);
        exp_q.push_back(S_WPMA); exp_q.push_back(S_WLINK); exp_q.push_back(S_RUN);
        manual_reset = 1'b1;
        link = 4'hF;
        step();
        manual_reset = 1'b0;
        check_val("mr_state", {29'd0, state_out}, {29'd0, S_RESET});
        check_val("mr_fault", {31'd0, fault}, 32'd0);
        check_val("mr_retry", {29'd0, retry_count}, 32'd0);
        check_val("mr_reset_all", {31'd0, gty_reset_all}, 32'd1);
        check_val("mr_drop", {31'd0, |drop_count}, 32'd0);
        wait_state(S_RUN, 1000);

        // No required lanes: RUNNING ignores links; WAIT_LINK passes in one cycle
        lane_required = 4'h0;
        link = 4'h0;
        repeat (10) step();
        check_val("req0_running", {29'd0, state_out}, {29'd0, S_RUN});
        exp_q.push_back(S_WPG); exp_q.push_back(S_SETTLE); exp_q.push_back(S_WPMA);
        exp_q.push_back(S_WLINK); exp_q.push_back(S_RUN);
        pwrgood = 4'b1110;
        repeat (3) step();
        pwrgood = 4'hF;
        wait_state(S_WLINK, 200);
        n = 0;
        while (state_out == S_WLINK && n < 50) begin
            step();
            n++;
        end
        check_val("req0_wlink_dwell", n, 1);
        check_val("req0_final", {29'd0, state_out}, {29'd0, S_RUN});
        repeat (5) step();

        check_val("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
